// File: rtl/apb_modport_pkg.sv
// rtl/apb_modport_pkg.sv - shared widths, depth and master FSM state type for apb_modport
package apb_modport_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 128;
  localparam int IDX_W     = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_mem_slave.sv
// rtl/apb_mem_slave.sv - APB3 memory slave, MEM_DEPTH x DATA_W, cleared on reset
// Optional wait state per access when APB_WAIT_STATE_EN is defined.
module apb_mem_slave
  import apb_modport_pkg::*;
(
  input  logic              PCLK,
  input  logic              RST,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [IDX_W-1:0]  PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic              access;

  assign access = PSEL && PENABLE;

`ifdef APB_WAIT_STATE_EN
  logic wait_done;

  // Low during the first ENABLE cycle, high in the second, cleared once the access completes.
  always_ff @(posedge PCLK or negedge RST) begin
    if (!RST) begin
      wait_done <= 1'b0;
    end else if (access) begin
      wait_done <= !wait_done;
    end else begin
      wait_done <= 1'b0;
    end
  end

  assign PREADY = wait_done;
`else
  assign PREADY = 1'b1;
`endif

  always_ff @(posedge PCLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (access && PREADY && PWRITE) begin
      mem[PADDR] <= PWDATA;
    end
  end

  assign PRDATA = (access && !PWRITE) ? mem[PADDR] : '0;

endmodule

// File: rtl/apb_modport.sv
// rtl/apb_modport.sv - APB3 bridge: command-port master FSM driving two memory slaves
// Build option: APB_WAIT_STATE_EN adds one slave wait state to every transfer.
module apb_modport
  import apb_modport_pkg::*;
(
  input  logic              PCLK,
  input  logic              RST,
  input  logic              transfer,
  input  logic              read_write,
  input  logic [ADDR_W-1:0] apb_write_paddr,
  input  logic [DATA_W-1:0] apb_write_data,
  input  logic [ADDR_W-1:0] apb_read_paddr,
  output logic [DATA_W-1:0] apb_read_data_out
);

  apb_state_e        state;
  logic              sel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;

  logic              psel1, psel2;
  logic [DATA_W-1:0] prdata1, prdata2, prdata;
  logic              pready1, pready2, pready;

  assign psel1  = sel & ~paddr[ADDR_W-1];
  assign psel2  = sel &  paddr[ADDR_W-1];
  assign prdata = paddr[ADDR_W-1] ? prdata2 : prdata1;
  assign pready = paddr[ADDR_W-1] ? pready2 : pready1;

  // Command fields are latched only on entry to SETUP and held through ENABLE.
  always_ff @(posedge PCLK or negedge RST) begin
    if (!RST) begin
      state             <= IDLE;
      sel               <= 1'b0;
      penable           <= 1'b0;
      pwrite            <= 1'b0;
      paddr             <= '0;
      pwdata            <= '0;
      apb_read_data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            state   <= SETUP;
            sel     <= 1'b1;
            penable <= 1'b0;
            pwrite  <= !read_write;
            paddr   <= read_write ? apb_read_paddr : apb_write_paddr;
            pwdata  <= apb_write_data;
          end
        end
        SETUP: begin
          state   <= ENABLE;
          penable <= 1'b1;
        end
        ENABLE: begin
          if (pready) begin
            if (!pwrite) begin
              apb_read_data_out <= prdata;
            end
            penable <= 1'b0;
            if (transfer) begin
              state  <= SETUP;
              pwrite <= !read_write;
              paddr  <= read_write ? apb_read_paddr : apb_write_paddr;
              pwdata <= apb_write_data;
            end else begin
              state <= IDLE;
              sel   <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          sel     <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

  apb_mem_slave u_slave1 (
    .PCLK    (PCLK),
    .RST     (RST),
    .PSEL    (psel1),
    .PENABLE (penable),
    .PWRITE  (pwrite),
    .PADDR   (paddr[IDX_W-1:0]),
    .PWDATA  (pwdata),
    .PRDATA  (prdata1),
    .PREADY  (pready1)
  );

  apb_mem_slave u_slave2 (
    .PCLK    (PCLK),
    .RST     (RST),
    .PSEL    (psel2),
    .PENABLE (penable),
    .PWRITE  (pwrite),
    .PADDR   (paddr[IDX_W-1:0]),
    .PWDATA  (pwdata),
    .PRDATA  (prdata2),
    .PREADY  (pready2)
  );

endmodule

// File: tb/tb_apb_modport.sv
// tb/tb_apb_modport.sv - scoreboard bench for apb_modport (honours APB_WAIT_STATE_EN)
module tb_apb_modport;
  import apb_modport_pkg::*;

`ifdef APB_WAIT_STATE_EN
  localparam int XFER = 3;
`else
  localparam int XFER = 2;
`endif

  logic       pclk = 1'b0;
  logic       rst = 1'b0;
  logic       transfer = 1'b0;
  logic       read_write = 1'b0;
  logic [7:0] apb_write_paddr = '0;
  logic [7:0] apb_write_data = '0;
  logic [7:0] apb_read_paddr = '0;
  logic [7:0] apb_read_data_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [256];
  logic [7:0] exp_q [$];
  logic [7:0] exp_v;

  typedef struct {
    logic       rw;
    logic [7:0] a;
    logic [7:0] d;
  } cmd_t;

  apb_modport dut (
    .PCLK              (pclk),
    .RST               (rst),
    .transfer          (transfer),
    .read_write        (read_write),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_paddr    (apb_read_paddr),
    .apb_read_data_out (apb_read_data_out)
  );

  always #5 pclk = ~pclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive a command and update the model / scoreboard at issue time.
  task automatic drive_cmd(input logic rw, input logic [7:0] a, input logic [7:0] d);
    read_write = rw;
    transfer   = 1'b1;
    if (rw) begin
      apb_read_paddr = a;
      exp_q.push_back(model[a]);
    end else begin
      apb_write_paddr = a;
      apb_write_data  = d;
      model[a]        = d;
    end
  endtask

  // Inputs changed after capture must not affect the transfer in flight.
  task automatic scramble(input logic [7:0] a, input logic [7:0] d);
    apb_read_paddr  = a ^ 8'h80;
    apb_write_paddr = a ^ 8'h80;
    apb_write_data  = ~d;
  endtask

  task automatic start_cmd(input logic rw, input logic [7:0] a, input logic [7:0] d);
    drive_cmd(rw, a, d);
    @(posedge pclk);
    @(negedge pclk);
    transfer = 1'b0;
    scramble(a, d);
  endtask

  task automatic run_single(input logic rw, input logic [7:0] a, input logic [7:0] d);
    start_cmd(rw, a, d);
    repeat (XFER) @(posedge pclk);
    @(negedge pclk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    checks++;
    if (apb_read_data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: got %h expected 00", apb_read_data_out);
    end
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", dut.state, IDLE);
    end
    checks++;
    if (dut.sel !== 1'b0 || dut.penable !== 1'b0) begin
      errors++;
      $display("FAIL reset_psel_penable: got %b%b expected 00", dut.sel, dut.penable);
    end
    rst = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    checks++;
    if (dut.state !== IDLE || apb_read_data_out !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_idle: state %0d out %h expected IDLE/00", dut.state, apb_read_data_out);
    end
  endtask

  task automatic test_round_trip;
    run_single(1'b0, 8'h05, 8'hA5);
    start_cmd(1'b1, 8'h05, 8'h00);
    repeat (XFER - 1) @(posedge pclk);
    @(negedge pclk);
    checks++;
    if (apb_read_data_out !== 8'h00) begin
      errors++;
      $display("FAIL read_latency_early: got %h expected 00", apb_read_data_out);
    end
    @(posedge pclk);
    @(negedge pclk);
    exp_v = exp_q.pop_front();
    checks++;
    if (apb_read_data_out !== exp_v || exp_v !== 8'hA5) begin
      errors++;
      $display("FAIL round_trip_05: got %h expected %h", apb_read_data_out, exp_v);
    end
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL round_trip_idle: got %0d expected %0d", dut.state, IDLE);
    end
  endtask

  task automatic test_isolation;
    run_single(1'b0, 8'h85, 8'h3C);
    run_single(1'b1, 8'h05, 8'h00);
    exp_v = exp_q.pop_front();
    checks++;
    if (apb_read_data_out !== exp_v) begin
      errors++;
      $display("FAIL isolation_05: got %h expected %h", apb_read_data_out, exp_v);
    end
    run_single(1'b1, 8'h85, 8'h00);
    exp_v = exp_q.pop_front();
    checks++;
    if (apb_read_data_out !== exp_v) begin
      errors++;
      $display("FAIL isolation_85: got %h expected %h", apb_read_data_out, exp_v);
    end
    run_single(1'b1, 8'h33, 8'h00);
    exp_v = exp_q.pop_front();
    checks++;
    if (apb_read_data_out !== exp_v) begin
      errors++;
      $display("FAIL unwritten_33: got %h expected %h", apb_read_data_out, exp_v);
    end
  endtask

  task automatic test_back_to_back;
    cmd_t tbl [10];
    tbl[0] = '{1'b0, 8'h10, 8'h11}; tbl[1] = '{1'b0, 8'h90, 8'h22};
    tbl[2] = '{1'b1, 8'h10, 8'h00}; tbl[3] = '{1'b1, 8'h90, 8'h00};
    tbl[4] = '{1'b0, 8'h10, 8'h5A}; tbl[5] = '{1'b1, 8'h10, 8'h00};
    tbl[6] = '{1'b1, 8'h90, 8'h00}; tbl[7] = '{1'b0, 8'h90, 8'h77};
    tbl[8] = '{1'b1, 8'h90, 8'h00}; tbl[9] = '{1'b1, 8'h10, 8'h00};
    for (int p = 0; p < 5; p++) begin
      drive_cmd(tbl[2*p].rw, tbl[2*p].a, tbl[2*p].d);
      @(posedge pclk);
      @(negedge pclk);
      drive_cmd(tbl[2*p+1].rw, tbl[2*p+1].a, tbl[2*p+1].d);
      repeat (XFER) @(posedge pclk);
      @(negedge pclk);
      if (tbl[2*p].rw) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (apb_read_data_out !== exp_v) begin
          errors++;
          $display("FAIL b2b_first pair %0d addr %h: got %h expected %h", p, tbl[2*p].a, apb_read_data_out, exp_v);
        end
      end
      transfer = 1'b0;
      scramble(tbl[2*p+1].a, tbl[2*p+1].d);
      repeat (XFER) @(posedge pclk);
      @(negedge pclk);
      if (tbl[2*p+1].rw) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (apb_read_data_out !== exp_v) begin
          errors++;
          $display("FAIL b2b_second pair %0d addr %h: got %h expected %h", p, tbl[2*p+1].a, apb_read_data_out, exp_v);
        end
      end
    end
  endtask

  task automatic test_reset_mid_transfer;
    read_write      = 1'b0;
    apb_write_paddr = 8'h20;
    apb_write_data  = 8'hFF;
    transfer        = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    transfer = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    checks++;
    if (apb_read_data_out !== 8'h00 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL async_reset: out %h state %0d expected 00/IDLE", apb_read_data_out, dut.state);
    end
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    run_single(1'b1, 8'h20, 8'h00);
    exp_v = exp_q.pop_front();
    checks++;
    if (apb_read_data_out !== exp_v) begin
      errors++;
      $display("FAIL aborted_write_20: got %h expected %h", apb_read_data_out, exp_v);
    end
    run_single(1'b1, 8'h90, 8'h00);
    exp_v = exp_q.pop_front();
    checks++;
    if (apb_read_data_out !== exp_v) begin
      errors++;
      $display("FAIL mem_cleared_90: got %h expected %h", apb_read_data_out, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_isolation();
    test_back_to_back();
    test_reset_mid_transfer();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
